// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         STALL_CNT_W = 16;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// being loaded by the instruction currently in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       MemReadEX,
  input  logic [4:0] WriteRegAddrEX,
  input  logic [4:0] Rs1AddrID,
  input  logic [4:0] Rs2AddrID,
  input  logic       UsesRs1ID,
  input  logic       UsesRs2ID,
  output logic       hazard
);

  logic dest_valid_s;
  logic rs1_match_s;
  logic rs2_match_s;

  // x0 is hard-wired to zero, so a load into it can never create a dependency
  assign dest_valid_s = MemReadEX && (WriteRegAddrEX != REG_ZERO);
  assign rs1_match_s  = UsesRs1ID && (Rs1AddrID == WriteRegAddrEX);
  assign rs2_match_s  = UsesRs2ID && (Rs2AddrID == WriteRegAddrEX);
  assign hazard       = dest_valid_s && (rs1_match_s || rs2_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: register enables/flushes for the 5-stage core,
// covering memory freezes with timeout, branch flushes and load-use bubbles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadEX,
  input  logic [4:0]  WriteRegAddrEX,
  input  logic [4:0]  Rs1AddrID,
  input  logic [4:0]  Rs2AddrID,
  input  logic        UsesRs1ID,
  input  logic        UsesRs2ID,
  input  logic        BranchTakenEX,
  input  logic        MemReqMEM,
  input  logic        MemAckMEM,
  output logic        PCEnable,
  output logic        IFIDEnable,
  output logic        IDEXEnable,
  output logic        EXMEMEnable,
  output logic        MEMWBEnable,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        MemReqOut,
  output logic        MemTimeout,
  output logic [15:0] StallCount
);

  localparam int                  WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  state_t                   state_r;
  state_t                   state_next_s;
  logic [WAIT_W-1:0]        wait_cnt_r;
  logic [WAIT_W-1:0]        wait_cnt_next_s;
  logic [STALL_CNT_W-1:0]   stall_cnt_r;
  logic                     mem_timeout_r;
  logic                     hazard_s;
  logic                     pc_en_s;
  logic                     ifid_en_s;
  logic                     idex_en_s;
  logic                     exmem_en_s;
  logic                     memwb_en_s;
  logic                     ifid_flush_s;
  logic                     idex_flush_s;
  logic                     mem_req_s;
  logic                     count_stall_s;

  load_use_detect u_load_use_detect (
    .MemReadEX      (MemReadEX),
    .WriteRegAddrEX (WriteRegAddrEX),
    .Rs1AddrID      (Rs1AddrID),
    .Rs2AddrID      (Rs2AddrID),
    .UsesRs1ID      (UsesRs1ID),
    .UsesRs2ID      (UsesRs2ID),
    .hazard         (hazard_s)
  );

  // Next-state and control decode; memory stall outranks branch flush outranks load-use
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    pc_en_s         = 1'b0;
    ifid_en_s       = 1'b0;
    idex_en_s       = 1'b0;
    exmem_en_s      = 1'b0;
    memwb_en_s      = 1'b0;
    ifid_flush_s    = 1'b0;
    idex_flush_s    = 1'b0;
    mem_req_s       = 1'b0;
    case (state_r)
      RUN: begin
        mem_req_s = MemReqMEM;
        if (MemReqMEM && !MemAckMEM) begin
          state_next_s    = MEM_WAIT;
          wait_cnt_next_s = '0;
        end else if (BranchTakenEX) begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end else if (hazard_s) begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b00111;
          idex_flush_s = 1'b1;
        end else begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
        end
      end
      MEM_WAIT: begin
        mem_req_s = 1'b1;
        if (MemAckMEM) begin
          // Release everything on the ack cycle so MEM/WB captures the read data
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
          state_next_s    = RUN;
          wait_cnt_next_s = '0;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_next_s    = ERROR;
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_next_s = ERROR;
      end
      default: begin
        state_next_s    = RUN;
        wait_cnt_next_s = '0;
      end
    endcase
  end

  assign count_stall_s = !pc_en_s && ((state_r == RUN) || (state_r == MEM_WAIT));

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wait_cnt_r    <= wait_cnt_next_s;
      mem_timeout_r <= mem_timeout_r || (state_next_s == ERROR);
    end
  end

  // Saturating stalled-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= '0;
    end else if (count_stall_s && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Reset forces every control low immediately, independent of the clock
  assign PCEnable    = reset && pc_en_s;
  assign IFIDEnable  = reset && ifid_en_s;
  assign IDEXEnable  = reset && idex_en_s;
  assign EXMEMEnable = reset && exmem_en_s;
  assign MEMWBEnable = reset && memwb_en_s;
  assign IFIDFlush   = reset && ifid_flush_s;
  assign IDEXFlush   = reset && idex_flush_s;
  assign MemReqOut   = reset && mem_req_s;
  assign MemTimeout  = reset && mem_timeout_r;
  assign StallCount  = reset ? stall_cnt_r : 16'd0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: table of single-cycle
// RUN vectors plus hand-written memory-wait, timeout and saturation sequences.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        MemReadEX;
  logic [4:0]  WriteRegAddrEX;
  logic [4:0]  Rs1AddrID;
  logic [4:0]  Rs2AddrID;
  logic        UsesRs1ID;
  logic        UsesRs2ID;
  logic        BranchTakenEX;
  logic        MemReqMEM;
  logic        MemAckMEM;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, mreq, mto;
  logic [15:0] scnt;
  logic        pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2, ifid_fl2, idex_fl2, mreq2, mto2;
  logic [15:0] scnt2;
  logic [7:0]  ctrl;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .MemReadEX(MemReadEX), .WriteRegAddrEX(WriteRegAddrEX),
    .Rs1AddrID(Rs1AddrID), .Rs2AddrID(Rs2AddrID),
    .UsesRs1ID(UsesRs1ID), .UsesRs2ID(UsesRs2ID),
    .BranchTakenEX(BranchTakenEX), .MemReqMEM(MemReqMEM), .MemAckMEM(MemAckMEM),
    .PCEnable(pc_en), .IFIDEnable(ifid_en), .IDEXEnable(idex_en),
    .EXMEMEnable(exmem_en), .MEMWBEnable(memwb_en),
    .IFIDFlush(ifid_fl), .IDEXFlush(idex_fl), .MemReqOut(mreq),
    .MemTimeout(mto), .StallCount(scnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(255)) dut_big (
    .clk(clk), .reset(reset),
    .MemReadEX(MemReadEX), .WriteRegAddrEX(WriteRegAddrEX),
    .Rs1AddrID(Rs1AddrID), .Rs2AddrID(Rs2AddrID),
    .UsesRs1ID(UsesRs1ID), .UsesRs2ID(UsesRs2ID),
    .BranchTakenEX(BranchTakenEX), .MemReqMEM(MemReqMEM), .MemAckMEM(MemAckMEM),
    .PCEnable(pc_en2), .IFIDEnable(ifid_en2), .IDEXEnable(idex_en2),
    .EXMEMEnable(exmem_en2), .MEMWBEnable(memwb_en2),
    .IFIDFlush(ifid_fl2), .IDEXFlush(idex_fl2), .MemReqOut(mreq2),
    .MemTimeout(mto2), .StallCount(scnt2)
  );

  // {PC, IFID, IDEX, EXMEM, MEMWB enables, IFIDFlush, IDEXFlush, MemReqOut}
  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, mreq};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] wr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       req;
    logic       ack;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic br, input logic req, input logic ack);
    MemReadEX = mr; WriteRegAddrEX = wr; Rs1AddrID = rs1; Rs2AddrID = rs2;
    UsesRs1ID = u1; UsesRs2ID = u2; BranchTakenEX = br; MemReqMEM = req; MemAckMEM = ack;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"lu_rs1",      1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00111_01_0};
    vecs[1] = '{"lu_x0",       1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11111_00_0};
    vecs[2] = '{"lu_no_use1",  1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11111_00_0};
    vecs[3] = '{"lu_rs2",      1'b1, 5'd5,  5'd3,  5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00111_01_0};
    vecs[4] = '{"no_load",     1'b0, 5'd5,  5'd5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11111_00_0};
    vecs[5] = '{"br_over_lu",  1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_11_0};
    vecs[6] = '{"req_ack_now", 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b11111_00_1};
    vecs[7] = '{"lu_no_use2",  1'b1, 5'd7,  5'd1,  5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11111_00_0};
    vecs[8] = '{"lu_x31",      1'b1, 5'd31, 5'd31, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00111_01_0};
    vecs[9] = '{"branch",      1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11111_11_0};

    reset = 1'b0;
    idle();
    #1;
    chk("reset_ctrl", {24'd0, ctrl}, 32'd0);
    chk("reset_cnt", {16'd0, scnt}, 32'd0);
    chk("reset_to", {31'd0, mto}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].mr, vecs[i].wr, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].br, vecs[i].req, vecs[i].ack);
      #1;
      chk(vecs[i].name, {24'd0, ctrl}, {24'd0, vecs[i].exp_ctrl});
    end

    // Load-use: one bubble cycle, then the flushed EX no longer matches
    do_reset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_seq_stall", {24'd0, ctrl}, {24'd0, 8'b00111_01_0});
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_seq_release", {24'd0, ctrl}, {24'd0, 8'b11111_00_0});
    chk("lu_seq_cnt", {16'd0, scnt}, 32'd1);

    // Memory access acknowledged after three stalled cycles
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("mem3_frozen", {24'd0, ctrl}, {24'd0, 8'b00000_00_1});
      @(negedge clk);
    end
    MemAckMEM = 1'b1;
    #1 chk("mem3_ack", {24'd0, ctrl}, {24'd0, 8'b11111_00_1});
    @(negedge clk);
    idle();
    #1 chk("mem3_run", {24'd0, ctrl}, {24'd0, 8'b11111_00_0});
    chk("mem3_cnt", {16'd0, scnt}, 32'd3);

    // Ack on the last permitted wait cycle still completes normally
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    MemAckMEM = 1'b1;
    #1 chk("lastack_ctrl", {24'd0, ctrl}, {24'd0, 8'b11111_00_1});
    @(negedge clk);
    idle();
    #1 chk("lastack_to", {31'd0, mto}, 32'd0);
    chk("lastack_run", {24'd0, ctrl}, {24'd0, 8'b11111_00_0});
    chk("lastack_cnt", {16'd0, scnt}, 32'd15);

    // No ack: trap to ERROR after 15 wait cycles
    do_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    #1 chk("to_pre_flag", {31'd0, mto}, 32'd0);
    chk("to_pre_ctrl", {24'd0, ctrl}, {24'd0, 8'b00000_00_1});
    @(negedge clk);
    #1 chk("to_flag", {31'd0, mto}, 32'd1);
    chk("to_ctrl", {24'd0, ctrl}, 32'd0);
    chk("to_cnt", {16'd0, scnt}, 32'd16);
    repeat (5) @(negedge clk);
    MemAckMEM = 1'b1;
    #1 chk("to_held", {31'd0, mto}, 32'd1);
    chk("to_cnt_frozen", {16'd0, scnt}, 32'd16);
    chk("to_ack_ignored", {24'd0, ctrl}, 32'd0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1 chk("to_rst_ctrl", {24'd0, ctrl}, 32'd0);
    chk("to_rst_flag", {31'd0, mto}, 32'd0);
    chk("to_rst_cnt", {16'd0, scnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("to_rst_run", {24'd0, ctrl}, {24'd0, 8'b11111_00_0});

    // Saturation on the long-timeout instance: 275 trips of 255 stalled cycles
    do_reset();
    for (int t = 0; t < 275; t++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (255) @(negedge clk);
      MemAckMEM = 1'b1;
      @(negedge clk);
    end
    idle();
    #1 chk("sat_cnt", {16'd0, scnt2}, 32'h0000_FFFF);
    chk("sat_no_to", {31'd0, mto2}, 32'd0);
    chk("sat_run", {24'd0, pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2,
                    ifid_fl2, idex_fl2, mreq2}, {24'd0, 8'b11111_00_0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
